// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier.
// FSM states, Booth digit encoding and the triplet decoder.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Digit bits: {neg, two, one}
  typedef logic [2:0] digit_t;

  localparam digit_t ZERO = 3'b000;
  localparam digit_t POS1 = 3'b001;
  localparam digit_t POS2 = 3'b010;
  localparam digit_t NEG1 = 3'b101;
  localparam digit_t NEG2 = 3'b110;

  function automatic digit_t booth_decode(
    input logic [2:0] t
  );
    digit_t d;
    case (t)
      3'b001,
      3'b010:  d = POS1;
      3'b011:  d = POS2;
      3'b100:  d = NEG2;
      3'b101,
      3'b110:  d = NEG1;
      default: d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_row.sv
// One Booth partial-product row: a, triplet in; pp (WIDTH+1, signed) out.
// Encoder plus one select/invert cell per bit, then +1 for negation.
module booth_pp_row
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       trip,
  output logic [WIDTH:0]   pp
);

  digit_t         dig;
  logic [WIDTH:0] a1;
  logic [WIDTH:0] a2;
  logic [WIDTH:0] mag;

  assign dig = booth_decode(trip);
  assign a1  = {a[WIDTH-1], a};
  assign a2  = {a, 1'b0};

  for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
    assign mag[i] = ((dig[0] & a1[i]) |
                     (dig[1] & a2[i])) ^ dig[2];
  end

  assign pp = mag + {{WIDTH{1'b0}}, dig[2]};

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative signed radix-4 Booth multiplier, one digit per cycle.
// in_valid/in_ready/in_a/in_b -> out_valid/out_ready/out_p; busy.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH/2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  logic [WIDTH:0]       b_ext;
  logic [CNT_W:0]       sh;
  logic [2:0]           trip;
  digit_t               dig;
  logic [WIDTH:0]       pp;
  logic                 sgn;
  logic [2*WIDTH-1:0]   pp_ext;
  logic [2*WIDTH-1:0]   pp_sh;
  logic                 last;

  assign b_ext = {b_q, 1'b0};
  assign sh    = {cnt_q, 1'b0};
  assign trip  = b_ext[sh +: 3];
  assign dig   = booth_decode(trip);
  assign last  = (cnt_q == CNT_W'(WIDTH/2 - 1));

  booth_pp_row #(
    .WIDTH (WIDTH)
  ) u_row (
    .a    (a_q),
    .trip (trip),
    .pp   (pp)
  );

  // -2A of the most negative A overflows WIDTH+1 bits;
  // take the extension sign from digit and A, not pp[WIDTH].
  assign sgn = (dig[0] | dig[1]) & (|a_q) &
               (dig[2] ^ a_q[WIDTH-1]);

  assign pp_ext = {{(WIDTH-1){sgn}}, pp};
  assign pp_sh  = pp_ext << sh;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + pp_sh;
        if (last) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_p     = acc_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (WIDTH=16).
// Scoreboard queue of reference products, one task per scenario.
module tb_booth_seq_mult;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  logic [2*W-1:0] sb[$];

  booth_seq_mult #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic signed [2*W-1:0] pa;
    logic signed [2*W-1:0] pb;
    pa = {{W{a[W-1]}}, a};
    pb = {{W{b[W-1]}}, b};
    return pa * pb;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic accept(input logic [W-1:0] a,
                        input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    sb.push_back(ref_mul(a, b));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int edges, output bit ok);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    ok = out_valid;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (out_p !== '0) begin
      failures++;
      $display("FAIL reset_out_p got=%h exp=0", out_p);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0]   ta[6] = '{16'd3, 16'hFFF9, 16'h8000,
                              16'h7FFF, 16'h0000, 16'hFFFF};
    logic [W-1:0]   tb[6] = '{16'd5, 16'd6, 16'h8000,
                              16'h8000, 16'h1234, 16'hFFFF};
    logic [2*W-1:0] te[6] = '{32'h0000000F, 32'hFFFFFFD6,
                              32'h40000000, 32'hC0008000,
                              32'h00000000, 32'h00000001};
    int edges;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      accept(ta[i], tb[i]);
      wait_out(edges, ok);
      checks++;
      if (!ok || edges != W/2) begin
        failures++;
        $display("FAIL latency[%0d] got=%0d exp=%0d", i, edges, W/2);
      end
      void'(sb.pop_front());
      checks++;
      if (out_p !== te[i]) begin
        failures++;
        $display("FAIL product[%0d] got=%h exp=%h", i, out_p, te[i]);
      end
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL done_flags[%0d] busy=%b in_ready=%b exp 1/0",
                 i, busy, in_ready);
      end
      handshake();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_flags[%0d] in_ready=%b out_valid=%b exp 1/0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    logic [2*W-1:0] exp;
    int edges;
    bit ok;
    accept(16'h1234, 16'hFEDC);
    wait_out(edges, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_timeout got=0 exp=1");
    end
    exp = sb.pop_front();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_p !== exp || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall[%0d] v=%b p=%h rdy=%b exp 1/%h/0",
                 i, out_valid, out_p, in_ready, exp);
      end
      @(negedge clk);
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release v=%b rdy=%b exp 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_ignore_in_valid();
    logic [2*W-1:0] exp;
    int n;
    accept(16'd100, 16'hFFFD);
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid = 1'b1;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    exp = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_p !== exp) begin
      failures++;
      $display("FAIL ignore v=%b got=%h exp=%h", out_valid, out_p, exp);
    end
    handshake();
  endtask

  task automatic test_mid_reset();
    int edges;
    bit ok;
    accept(16'd2, 16'd3);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        busy !== 1'b0 || out_p !== '0) begin
      failures++;
      $display("FAIL mid_reset rdy=%b v=%b busy=%b p=%h exp 1/0/0/0",
               in_ready, out_valid, busy, out_p);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    accept(16'd2, 16'd3);
    wait_out(edges, ok);
    void'(sb.pop_front());
    checks++;
    if (!ok || out_p !== 32'h00000006) begin
      failures++;
      $display("FAIL after_reset got=%h exp=00000006", out_p);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] exp;
    int sent = 0;
    int recv = 0;
    int last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && recv < 4; cyc++) begin
      @(negedge clk);
      in_valid = (sent < 4);
      if (in_valid && in_ready) begin
        in_a = pick();
        in_b = pick();
        sb.push_back(ref_mul(in_a, in_b));
        if (last >= 0) begin
          checks++;
          if (cyc - last != W/2 + 2) begin
            failures++;
            $display("FAIL b2b_interval got=%0d exp=%0d",
                     cyc - last, W/2 + 2);
          end
        end
        last = cyc;
        sent++;
      end
      if (out_valid && out_ready) begin
        exp = sb.pop_front();
        checks++;
        if (out_p !== exp) begin
          failures++;
          $display("FAIL b2b_product got=%h exp=%h", out_p, exp);
        end
        recv++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (recv != 4) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=4", recv);
    end
  endtask

  task automatic test_random();
    localparam int N = 2000;
    logic [2*W-1:0] exp;
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    while (recv < N && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (sent < N) && ($urandom_range(3) != 0);
      in_a      = pick();
      in_b      = pick();
      out_ready = ($urandom_range(3) != 0);
      if (in_valid && in_ready) begin
        sb.push_back(ref_mul(in_a, in_b));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rand_extra_output got=%h exp=none", out_p);
        end else begin
          exp = sb.pop_front();
          if (out_p !== exp) begin
            failures++;
            $display("FAIL rand_product[%0d] got=%h exp=%h",
                     recv, out_p, exp);
          end
        end
        recv++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (recv != N || sb.size() != 0) begin
      failures++;
      $display("FAIL rand_count got=%0d left=%0d exp=%0d/0",
               recv, sb.size(), N);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_ignore_in_valid();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
